// File: rtl/io_uart_if.sv
// Register bus between the memory controller's IO port and io_uart.
//   address : register index (IO_ADDR_BITS wide)
//   dataIn  : 32-bit write data, qualified by wEn
//   dataOut : 32-bit read data, combinational from address
//   wEn     : write strobe, sampled on the rising clock edge
// The master modport is the controller side, the slave modport is the peripheral.
interface io_uart_if #(
  parameter int IO_ADDR_BITS = 2
);
  logic [IO_ADDR_BITS-1:0] address;
  logic [31:0]             dataIn;
  logic [31:0]             dataOut;
  logic                    wEn;

  modport master (output address, output dataIn, output wEn, input dataOut);
  modport slave  (input address, input dataIn, input wEn, output dataOut);
endinterface

// File: rtl/io_uart.sv
// Memory-mapped UART: 8N1 transmitter and receiver with a programmable
// clocks-per-bit divisor and a receive interrupt.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : register bus (slave side); reads are combinational
//          0 TXDATA  1 RXDATA  2 STATUS (W1C)  3 CTRL {rx_ie, div}
//   txd  : serial output, idles high
//   rxd  : serial input, asynchronous to clk
//   irq  : high while a received byte is pending and rx_ie is set
module io_uart #(
  parameter int IO_ADDR_BITS = 2,
  parameter int DIV_BITS     = 16,
  parameter int DEFAULT_DIV  = 434
) (
  input  logic       clk,
  input  logic       rst,
  io_uart_if.slave   bus,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);
  localparam logic [IO_ADDR_BITS-1:0] REG_TXDATA = IO_ADDR_BITS'(0);
  localparam logic [IO_ADDR_BITS-1:0] REG_RXDATA = IO_ADDR_BITS'(1);
  localparam logic [IO_ADDR_BITS-1:0] REG_STATUS = IO_ADDR_BITS'(2);
  localparam logic [IO_ADDR_BITS-1:0] REG_CTRL   = IO_ADDR_BITS'(3);
  localparam logic [DIV_BITS-1:0]     ONE        = DIV_BITS'(1);
  localparam logic [DIV_BITS-1:0]     MIN_DIV    = DIV_BITS'(2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DIV_BITS-1:0] div_q;
  logic                rx_ie;
  logic                wr_tx, wr_status, wr_ctrl, clr_valid;
  logic [DIV_BITS-1:0] div_wr;
  logic                unused_bits;

  assign wr_tx     = bus.wEn && (bus.address == REG_TXDATA);
  assign wr_status = bus.wEn && (bus.address == REG_STATUS);
  assign wr_ctrl   = bus.wEn && (bus.address == REG_CTRL);
  assign clr_valid = wr_status && bus.dataIn[1];
  // A divisor below 2 would leave no room for the half-bit start sample.
  assign div_wr    = (bus.dataIn[DIV_BITS-1:0] < MIN_DIV) ? MIN_DIV : bus.dataIn[DIV_BITS-1:0];
  assign unused_bits = ^bus.dataIn[31:17];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_BITS'(DEFAULT_DIV);
      rx_ie <= 1'b0;
    end else if (wr_ctrl) begin
      div_q <= div_wr;
      rx_ie <= bus.dataIn[16];
    end
  end

  // Transmitter
  state_t              tx_state;
  logic [DIV_BITS-1:0] tx_cnt, tx_div;
  logic [2:0]          tx_bit;
  logic [7:0]          tx_shift;
  logic                tx_tick, tx_busy;

  assign tx_tick = (tx_cnt == tx_div - ONE);
  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: if (wr_tx) begin
          tx_state <= S_START;
          txd      <= 1'b0;
          tx_shift <= bus.dataIn[7:0];
          tx_div   <= div_q;
          tx_cnt   <= '0;
        end
        S_START: if (tx_tick) begin
          tx_state <= S_DATA;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          txd      <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
        end else tx_cnt <= tx_cnt + ONE;
        S_DATA: if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            txd      <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end else tx_cnt <= tx_cnt + ONE;
        S_STOP: if (tx_tick) begin
          tx_state <= S_IDLE;
          tx_cnt   <= '0;
        end else tx_cnt <= tx_cnt + ONE;
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Receiver
  state_t              rx_state;
  logic [DIV_BITS-1:0] rx_cnt, rx_div;
  logic [2:0]          rx_bit;
  logic [7:0]          rx_shift, rx_byte;
  logic                rx_s1, rx_s2;
  logic                rx_valid, overrun, frame_err;
  logic                rx_tick, rx_half;

  assign rx_tick = (rx_cnt == rx_div - ONE);
  assign rx_half = (rx_cnt == (rx_div >> 1) - ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1     <= 1'b1;  // synchroniser idles high so reset cannot fake a start bit
      rx_s2     <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_div    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      // Software clears first; a hardware set later in this block wins.
      if (wr_status) begin
        if (bus.dataIn[1]) rx_valid  <= 1'b0;
        if (bus.dataIn[2]) overrun   <= 1'b0;
        if (bus.dataIn[3]) frame_err <= 1'b0;
      end
      case (rx_state)
        S_IDLE: if (!rx_s2) begin
          rx_state <= S_START;
          rx_cnt   <= '0;
          rx_div   <= div_q;
        end
        S_START: if (rx_half) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;  // high at mid-start is a glitch
        end else rx_cnt <= rx_cnt + ONE;
        S_DATA: if (rx_tick) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + ONE;
        S_STOP: if (rx_tick) begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
          if (!rx_s2) frame_err <= 1'b1;
          else if (rx_valid && !clr_valid) overrun <= 1'b1;
          else begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
          end
        end else rx_cnt <= rx_cnt + ONE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign irq = rx_valid && rx_ie;

  always_comb begin
    bus.dataOut = '0;
    case (bus.address)
      REG_RXDATA: bus.dataOut = {23'b0, rx_valid, rx_byte};
      REG_STATUS: bus.dataOut = {28'b0, frame_err, overrun, rx_valid, tx_busy};
      REG_CTRL:   bus.dataOut = {15'b0, rx_ie, 16'(div_q)};
      default:    bus.dataOut = '0;
    endcase
  end
endmodule
